uart_tx: RTL and testbench

//  UART transmitter; the send-side counterpart of the UART receiver in stage1/task6_uart.

---
 rtl/uart_pkg.sv | 22 ++
 rtl/uart_baud_cnt.sv | 26 ++
 rtl/uart_tx.sv | 132 +++++++++++++
 tb/tb_uart_tx.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit path: state encoding, parity modes, defaults.
package uart_pkg;

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_START  = 3'd1;
    localparam logic [2:0] ST_DATA   = 3'd2;
    localparam logic [2:0] ST_PARITY = 3'd3;
    localparam logic [2:0] ST_STOP   = 3'd4;

    localparam int unsigned PAR_NONE = 0;
    localparam int unsigned PAR_ODD  = 1;
    localparam int unsigned PAR_EVEN = 2;

    localparam int unsigned DEF_BPS_MAX = 5208;
    localparam int unsigned DEF_BIT_MAX = 8;

    // Zero-extension of narrower data words leaves the XOR reduction unchanged.
    function automatic logic calc_parity(input logic [7:0] data, input int unsigned mode);
        return (mode == PAR_EVEN) ? ^data : ~^data;
    endfunction

endpackage

// File: rtl/uart_baud_cnt.sv
// Bit-time counter: counts 0..BPS_MAX-1 while enabled, held at zero otherwise.
module uart_baud_cnt #(
    parameter int unsigned BPS_MAX = 5208
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       en,
    output logic [$clog2(BPS_MAX)-1:0] cnt,
    output logic                       end_bps
);

    localparam int unsigned CW = $clog2(BPS_MAX);

    assign end_bps = en && (cnt == CW'(BPS_MAX - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (!en || end_bps) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + CW'(1);
        end
    end

endmodule

// File: rtl/uart_tx.sv
// UART transmitter: one byte per valid/ready handshake, start / LSB-first data /
// optional parity / stop bits serialised onto a registered tx line.
module uart_tx
    import uart_pkg::*;
#(
    parameter int unsigned BPS_MAX   = DEF_BPS_MAX,
    parameter int unsigned BIT_MAX   = DEF_BIT_MAX,
    parameter int unsigned PARITY    = PAR_NONE,
    parameter int unsigned STOP_BITS = 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [BIT_MAX-1:0] tx_data,
    input  logic               tx_valid,
    output logic               tx_ready,
    output logic               tx_busy,
    output logic               tx_done,
    output logic               tx
);

    localparam int unsigned BCW     = $clog2(BPS_MAX);
    localparam int unsigned NCW     = $clog2(BIT_MAX);
    localparam bit          HAS_PAR = (PARITY != PAR_NONE);

    logic [2:0]         state, state_nxt;
    logic [BIT_MAX-1:0] shift_q, shift_nxt;
    logic [NCW-1:0]     bit_cnt, bit_cnt_nxt;
    logic               par_q, par_nxt;
    logic               tx_nxt, done_nxt;
    logic [BCW-1:0]     bps_cnt;
    logic               end_bps;

    uart_baud_cnt #(.BPS_MAX(BPS_MAX)) u_baud (
        .clk     (clk),
        .rst     (rst),
        .en      (state != ST_IDLE),
        .cnt     (bps_cnt),
        .end_bps (end_bps)
    );

    assign tx_ready = (state == ST_IDLE);
    assign tx_busy  = ~tx_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= ST_IDLE;
            shift_q <= '0;
            bit_cnt <= '0;
            par_q   <= 1'b0;
            tx      <= 1'b1;
            tx_done <= 1'b0;
        end else begin
            state   <= state_nxt;
            shift_q <= shift_nxt;
            bit_cnt <= bit_cnt_nxt;
            par_q   <= par_nxt;
            tx      <= tx_nxt;
            tx_done <= done_nxt;
        end
    end

    // bit_cnt indexes data bits in DATA and is reused to count stop bits in STOP.
    always_comb begin
        state_nxt   = state;
        shift_nxt   = shift_q;
        bit_cnt_nxt = bit_cnt;
        par_nxt     = par_q;
        tx_nxt      = tx;
        done_nxt    = 1'b0;
        case (state)
            ST_IDLE: begin
                if (tx_valid) begin
                    shift_nxt = tx_data;
                    par_nxt   = calc_parity(8'(tx_data), PARITY);
                    tx_nxt    = 1'b0;
                    state_nxt = ST_START;
                end
            end
            ST_START: begin
                if (end_bps) begin
                    tx_nxt    = shift_q[0];
                    shift_nxt = shift_q >> 1;
                    state_nxt = ST_DATA;
                end
            end
            ST_DATA: begin
                if (end_bps) begin
                    if (bit_cnt == NCW'(BIT_MAX - 1)) begin
                        bit_cnt_nxt = '0;
                        if (HAS_PAR) begin
                            tx_nxt    = par_q;
                            state_nxt = ST_PARITY;
                        end else begin
                            tx_nxt    = 1'b1;
                            state_nxt = ST_STOP;
                        end
                    end else begin
                        bit_cnt_nxt = bit_cnt + NCW'(1);
                        tx_nxt      = shift_q[0];
                        shift_nxt   = shift_q >> 1;
                    end
                end
            end
            ST_PARITY: begin
                if (end_bps) begin
                    tx_nxt    = 1'b1;
                    state_nxt = ST_STOP;
                end
            end
            ST_STOP: begin
                if (end_bps) begin
                    if (bit_cnt == NCW'(STOP_BITS - 1)) begin
                        bit_cnt_nxt = '0;
                        done_nxt    = 1'b1;
                        state_nxt   = ST_IDLE;
                    end else begin
                        bit_cnt_nxt = bit_cnt + NCW'(1);
                    end
                end
            end
            default: begin
                tx_nxt    = 1'b1;
                state_nxt = ST_IDLE;
            end
        endcase
    end

    // The bit-time counter must be parked at zero whenever no frame is in flight.
    a_idle_cnt: assert property (@(posedge clk) disable iff (rst)
        (state == ST_IDLE) |-> (bps_cnt == '0));

endmodule

// File: tb/tb_uart_tx.sv
// Scoreboard bench for uart_tx: four instances (no parity, even, odd, two stop bits) at BPS_MAX=4.
module tb_uart_tx;

    localparam int unsigned BPS = 4;
    localparam int          NU  = 4;

    typedef struct packed {
        logic [3:0] unit;
        logic [7:0] data;
        logic       par;
        logic       b2b;
        logic       abort;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [7:0]    tx_data = 8'h00;
    logic [NU-1:0] tx_valid = '0;
    logic [NU-1:0] tx_ready, tx_busy, tx_done, tx;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    for (genvar g = 0; g < NU; g++) begin : g_u
        localparam int unsigned PAR   = (g == 1) ? 2 : ((g == 2) ? 1 : 0);
        localparam int unsigned STOPS = (g == 3) ? 2 : 1;

        uart_tx #(.BPS_MAX(BPS), .BIT_MAX(8), .PARITY(PAR), .STOP_BITS(STOPS)) dut (
            .clk      (clk),
            .rst      (rst),
            .tx_data  (tx_data),
            .tx_valid (tx_valid[g]),
            .tx_ready (tx_ready[g]),
            .tx_busy  (tx_busy[g]),
            .tx_done  (tx_done[g]),
            .tx       (tx[g])
        );

        // Monitor: detects each start bit, pops the expected frame and checks it bit by bit.
        initial begin : mon
            exp_t        e;
            logic [15:0] fb;
            int          nb;
            int          last_end;
            bit          ok, ab;
            logic        bad_tx;
            last_end = -100;
            forever begin
                @(negedge clk);
                if (rst) continue;
                if (tx_done[g]) begin
                    errors++;
                    $display("FAIL u%0d spurious_done: tx_done=1 required 0 at cycle %0d", g, cyc);
                end
                if (tx[g] !== 1'b0) continue;
                checks++;
                if (sb.size() == 0) begin
                    errors++;
                    $display("FAIL u%0d unexpected_frame: start bit seen, required none at cycle %0d", g, cyc);
                    for (int i = 0; i < 200 && !tx_ready[g]; i++) @(negedge clk);
                    continue;
                end
                e = sb.pop_front();
                if (e.unit != 4'(g)) begin
                    errors++;
                    $display("FAIL u%0d frame_owner: frame from unit %0d required unit %0d", g, g, e.unit);
                end
                if (e.b2b) begin
                    checks++;
                    if (cyc != last_end + 1) begin
                        errors++;
                        $display("FAIL u%0d idle_gap: gap %0d clk required 1", g, cyc - last_end);
                    end
                end
                fb = '1;
                fb[0] = 1'b0;
                for (int i = 0; i < 8; i++) fb[1+i] = e.data[i];
                nb = 9;
                if (PAR != 0) begin
                    fb[nb] = e.par;
                    nb++;
                end
                nb += STOPS;
                ab = 1'b0;
                for (int b = 0; b < nb && !ab; b++) begin
                    ok = 1'b1;
                    bad_tx = fb[b];
                    for (int c = 0; c < int'(BPS); c++) begin
                        if (b != 0 || c != 0) @(negedge clk);
                        if (rst) begin
                            ab = 1'b1;
                            break;
                        end
                        if (tx[g] !== fb[b] || tx_done[g] || tx_ready[g] || !tx_busy[g]) begin
                            ok = 1'b0;
                            bad_tx = tx[g];
                        end
                    end
                    if (!ab) begin
                        checks++;
                        if (!ok) begin
                            errors++;
                            $display("FAIL u%0d data=%h bit%0d: tx=%b (or done/ready/busy wrong) required tx=%b held %0d clk",
                                     g, e.data, b, bad_tx, fb[b], BPS);
                        end
                    end
                end
                checks++;
                if (ab) begin
                    if (!e.abort) begin
                        errors++;
                        $display("FAIL u%0d data=%h unexpected_abort: frame cut by reset, required complete", g, e.data);
                    end
                    while (rst) @(negedge clk);
                    continue;
                end
                if (e.abort) begin
                    errors++;
                    $display("FAIL u%0d data=%h not_aborted: frame completed, required reset abort", g, e.data);
                end
                @(negedge clk);
                checks++;
                if (rst || tx_done[g] !== 1'b1 || tx_ready[g] !== 1'b1 || tx_busy[g] !== 1'b0 || tx[g] !== 1'b1) begin
                    errors++;
                    $display("FAIL u%0d data=%h frame_end: done=%b ready=%b busy=%b tx=%b required 1 1 0 1",
                             g, e.data, tx_done[g], tx_ready[g], tx_busy[g], tx[g]);
                end
                last_end = cyc;
            end
        end
    end

    task automatic send(input int u, input logic [7:0] d, input logic par,
                        input logic b2b, input logic abort, input bit hold);
        exp_t e;
        bit   acc;
        e.unit  = 4'(u);
        e.data  = d;
        e.par   = par;
        e.b2b   = b2b;
        e.abort = abort;
        sb.push_back(e);
        tx_data     = d;
        tx_valid[u] = 1'b1;
        acc = 1'b0;
        for (int i = 0; i < 400 && !acc; i++) begin
            @(negedge clk);
            if (tx_ready[u]) acc = 1'b1;
        end
        @(posedge clk);
        #1;
        checks++;
        if (!acc) begin
            errors++;
            $display("FAIL u%0d accept_timeout: data=%h not accepted, required accept", u, d);
        end
        if (!hold) tx_valid[u] = 1'b0;
    endtask

    task automatic wait_idle(input int u);
        bit rdy;
        rdy = 1'b0;
        for (int i = 0; i < 400 && !rdy; i++) begin
            @(negedge clk);
            if (tx_ready[u]) rdy = 1'b1;
        end
        checks++;
        if (!rdy) begin
            errors++;
            $display("FAIL u%0d idle_timeout: tx_ready=0 required 1", u);
        end
        repeat (4) @(posedge clk);
        #1;
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        for (int u = 0; u < NU; u++) begin
            checks++;
            if (tx[u] !== 1'b1 || tx_ready[u] !== 1'b1 || tx_busy[u] !== 1'b0 || tx_done[u] !== 1'b0) begin
                errors++;
                $display("FAIL u%0d reset_state: tx=%b ready=%b busy=%b done=%b required 1 1 0 0",
                         u, tx[u], tx_ready[u], tx_busy[u], tx_done[u]);
            end
        end
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Plain 8N1 frame
        send(0, 8'h55, 1'b0, 1'b0, 1'b0, 1'b0);
        wait_idle(0);

        // Parity: 0x07 has three ones -> even parity 1, odd parity 0
        send(1, 8'h07, 1'b1, 1'b0, 1'b0, 1'b0);
        wait_idle(1);
        send(2, 8'h07, 1'b0, 1'b0, 1'b0, 1'b0);
        wait_idle(2);

        // Back-to-back with tx_valid held high
        send(0, 8'hA3, 1'b0, 1'b0, 1'b0, 1'b1);
        send(0, 8'h3C, 1'b0, 1'b1, 1'b0, 1'b0);
        wait_idle(0);

        // tx_valid pulse and tx_data change during DATA must be ignored
        send(0, 8'hC9, 1'b0, 1'b0, 1'b0, 1'b0);
        repeat (15) @(posedge clk);
        #1;
        tx_data     = 8'hFF;
        tx_valid[0] = 1'b1;
        @(posedge clk);
        #1;
        tx_valid[0] = 1'b0;
        wait_idle(0);
        repeat (20) @(posedge clk);
        #1;

        // Reset during data bit 3, then a clean frame
        send(0, 8'hB2, 1'b0, 1'b0, 1'b1, 1'b0);
        repeat (17) @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        checks++;
        if (tx[0] !== 1'b1 || tx_ready[0] !== 1'b1 || tx_done[0] !== 1'b0) begin
            errors++;
            $display("FAIL u0 async_reset: tx=%b ready=%b done=%b required 1 1 0", tx[0], tx_ready[0], tx_done[0]);
        end
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        send(0, 8'h96, 1'b0, 1'b0, 1'b0, 1'b0);
        wait_idle(0);

        // Two stop bits
        send(3, 8'h5A, 1'b0, 1'b0, 1'b0, 1'b0);
        wait_idle(3);

        for (int i = 0; i < 200 && sb.size() != 0; i++) @(posedge clk);
        repeat (5) @(posedge clk);
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: %0d frames outstanding required 0", sb.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
